regfile_writeback: RTL and testbench

Write-side front end for the CPU's 32x32 register file. It merges single-cycle ALU results with long-latency load/store-unit (LSU) results into the register file's single write port (we/rd/wd). It keeps a busy scoreboard for in-flight long-latency destinations, which drives the decode-stage hazard flags. A starvation guard stops a continuous ALU result stream from blocking buffered LSU results indefinitely.

---
 rtl/regfile_writeback_if.sv | 36 +++
 rtl/regfile_writeback.sv | 115 +++++++++++
 tb/tb_regfile_writeback.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Signal bundle between the pipeline and the register-file write-back front end.
// The pipeline side is master; the write-back block is slave.
interface regfile_writeback_if #(
   parameter int unsigned XLEN = 32
);
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_wd;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_wd;
   logic            we;
   logic [4:0]      rd;
   logic [XLEN-1:0] wd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            hz1;
   logic            hz2;
   logic [31:0]     busy;
   logic            alu_stall;

   modport master (
      output issue_valid, issue_rd, alu_valid, alu_rd, alu_wd,
      output lsu_valid, lsu_rd, lsu_wd, rs1, rs2,
      input  lsu_ready, we, rd, wd, hz1, hz2, busy, alu_stall
   );

   modport slave (
      input  issue_valid, issue_rd, alu_valid, alu_rd, alu_wd,
      input  lsu_valid, lsu_rd, lsu_wd, rs1, rs2,
      output lsu_ready, we, rd, wd, hz1, hz2, busy, alu_stall
   );
endinterface

// File: rtl/regfile_writeback.sv
// Merges ALU and buffered LSU results onto the single register-file write port,
// tracks in-flight long-latency destinations and guards LSU results against starvation.
module regfile_writeback #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned LQ_DEPTH   = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic                s_clk,
   input logic                s_reset_n,
   regfile_writeback_if.slave bus
);
   localparam int unsigned PtrW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(LQ_DEPTH + 1);
   localparam int unsigned StvW = $clog2(STARVE_MAX + 1);

   logic [4:0]      r_q_rd [LQ_DEPTH];
   logic [XLEN-1:0] r_q_wd [LQ_DEPTH];
   logic [PtrW-1:0] r_wptr;
   logic [PtrW-1:0] r_rptr;
   logic [CntW-1:0] r_count;
   logic [StvW-1:0] r_starve;
   logic            r_stall;
   logic            r_we;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_wd;
   logic [31:0]     r_busy;

   logic            w_empty;
   logic            w_ready;
   logic            w_push;
   logic            w_pop;
   logic [4:0]      w_head_rd;
   logic [XLEN-1:0] w_head_wd;
   logic [31:0]     w_busy_d;
   logic [StvW-1:0] w_starve_d;
   logic            w_stall_d;

   assign w_empty   = (r_count == '0);
   assign w_ready   = (r_count < CntW'(LQ_DEPTH));
   assign w_push    = bus.lsu_valid && w_ready;
   assign w_pop     = !bus.alu_valid && !w_empty;
   assign w_head_rd = r_q_rd[r_rptr];
   assign w_head_wd = r_q_wd[r_rptr];

   // Pop clears before issue sets, so a same-cycle re-issue keeps the register busy.
   always_comb begin
      w_busy_d = r_busy;
      if (w_pop) w_busy_d[w_head_rd] = 1'b0;
      if (bus.issue_valid && (bus.issue_rd != 5'd0)) w_busy_d[bus.issue_rd] = 1'b1;
      w_busy_d[0] = 1'b0;
   end

   // A non-empty FIFO without a pop means the ALU took the port this cycle.
   always_comb begin
      w_starve_d = r_starve;
      if (w_empty || w_pop) begin
         w_starve_d = '0;
      end else if (r_starve != StvW'(STARVE_MAX)) begin
         w_starve_d = r_starve + StvW'(1);
      end
      w_stall_d = w_pop ? 1'b0 : (r_stall | (r_starve == StvW'(STARVE_MAX)));
   end

   always_ff @(posedge s_clk) begin
      if (w_push) begin
         r_q_rd[r_wptr] <= bus.lsu_rd;
         r_q_wd[r_wptr] <= bus.lsu_wd;
      end
   end

   always_ff @(posedge s_clk or negedge s_reset_n) begin
      if (!s_reset_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_stall  <= 1'b0;
         r_busy   <= '0;
         r_we     <= 1'b0;
         r_rd     <= '0;
         r_wd     <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PtrW'(1);
         if (w_pop) r_rptr <= r_rptr + PtrW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
         r_starve <= w_starve_d;
         r_stall  <= w_stall_d;
         r_busy   <= w_busy_d;
         if (bus.alu_valid) begin
            r_we <= (bus.alu_rd != 5'd0);
            r_rd <= bus.alu_rd;
            r_wd <= bus.alu_wd;
         end else if (w_pop) begin
            r_we <= (w_head_rd != 5'd0);
            r_rd <= w_head_rd;
            r_wd <= w_head_wd;
         end else begin
            r_we <= 1'b0;
         end
      end
   end

   assign bus.lsu_ready = w_ready;
   assign bus.we        = r_we;
   assign bus.rd        = r_rd;
   assign bus.wd        = r_wd;
   assign bus.busy      = r_busy;
   assign bus.hz1       = r_busy[bus.rs1];
   assign bus.hz2       = r_busy[bus.rs2];
   assign bus.alu_stall = r_stall;
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned LQ     = 2;
   localparam int unsigned STARVE = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] wd;
   } ent_t;

   logic s_clk = 1'b0;
   logic s_reset_n;

   regfile_writeback_if #(.XLEN(XLEN)) bus ();

   regfile_writeback #(
      .XLEN       (XLEN),
      .LQ_DEPTH   (LQ),
      .STARVE_MAX (STARVE)
   ) dut (
      .s_clk     (s_clk),
      .s_reset_n (s_reset_n),
      .bus       (bus)
   );

   always #5 s_clk = ~s_clk;

   int n_checks = 0;
   int n_errs   = 0;

   // Reference model state
   ent_t        m_q[$];
   logic [31:0] m_busy;
   int          m_run;
   bit          m_stall;
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_wd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_busy  = '0;
      m_run   = 0;
      m_stall = 1'b0;
      m_we    = 1'b0;
      m_rd    = '0;
      m_wd    = '0;
   endtask

   // One clock of the write-back rules, applied to the inputs currently driven.
   task automatic model_step();
      bit   nonempty;
      bit   popped;
      bit   accept;
      int   run_old;
      ent_t h;
      nonempty = (m_q.size() != 0);
      accept   = bus.lsu_valid && (m_q.size() < LQ);
      popped   = 1'b0;
      run_old  = m_run;
      if (bus.alu_valid) begin
         m_we = (bus.alu_rd != 0);
         m_rd = bus.alu_rd;
         m_wd = bus.alu_wd;
      end else if (nonempty) begin
         h      = m_q.pop_front();
         popped = 1'b1;
         m_we   = (h.rd != 0);
         m_rd   = h.rd;
         m_wd   = h.wd;
         m_busy[h.rd] = 1'b0;
      end else begin
         m_we = 1'b0;
      end
      if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
      if (accept) m_q.push_back('{rd: bus.lsu_rd, wd: bus.lsu_wd});
      m_run   = (popped || !nonempty) ? 0 : m_run + 1;
      m_stall = popped ? 1'b0 : (m_stall || (run_old >= STARVE));
   endtask

   task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] awd,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] lwd,
                        input bit iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
      @(negedge s_clk);
      bus.alu_valid   = av;
      bus.alu_rd      = ard;
      bus.alu_wd      = awd;
      bus.lsu_valid   = lv;
      bus.lsu_rd      = lrd;
      bus.lsu_wd      = lwd;
      bus.issue_valid = iv;
      bus.issue_rd    = ird;
      bus.rs1         = r1;
      bus.rs2         = r2;
      #1;
      chk("lsu_ready", bus.lsu_ready, m_q.size() < LQ);
      chk("hz1", bus.hz1, m_busy[r1]);
      chk("hz2", bus.hz2, m_busy[r2]);
      model_step();
      @(posedge s_clk);
      #1;
      chk("we", bus.we, m_we);
      chk("rd", bus.rd, m_rd);
      chk("wd", bus.wd, m_wd);
      chk("busy", bus.busy, m_busy);
      chk("alu_stall", bus.alu_stall, m_stall);
   endtask

   task automatic idle(input logic [4:0] r1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   task automatic reset_checks();
      chk("rst_we", bus.we, 1'b0);
      chk("rst_rd", bus.rd, 5'd0);
      chk("rst_wd", bus.wd, 32'd0);
      chk("rst_busy", bus.busy, 32'd0);
      chk("rst_stall", bus.alu_stall, 1'b0);
      chk("rst_ready", bus.lsu_ready, 1'b1);
   endtask

   task automatic pulse_reset();
      s_reset_n = 1'b0;
      #1;
      reset_checks();
      model_reset();
      #1;
      s_reset_n = 1'b1;
   endtask

   initial begin
      bit   av;
      int   mode;
      s_reset_n       = 1'b0;
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_wd      = '0;
      bus.lsu_valid   = 1'b0;
      bus.lsu_rd      = '0;
      bus.lsu_wd      = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.rs1         = '0;
      bus.rs2         = '0;
      model_reset();
      #11;
      reset_checks();
      #1;
      s_reset_n = 1'b1;

      // ALU path
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      chk("alu_we", bus.we, 1'b1);
      chk("alu_rd", bus.rd, 5'd5);
      chk("alu_wd", bus.wd, 32'hDEADBEEF);
      idle(0);
      chk("alu_we_off", bus.we, 1'b0);

      // LSU with scoreboard
      drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      chk("busy7_set", bus.busy[7], 1'b1);
      chk("hz1_set", bus.hz1 == 1'b1 || bus.rs1 != 7, 1'b1);
      drive(0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
      chk("hz1_busy", bus.hz1, 1'b1);
      idle(7);
      chk("lsu_we", bus.we, 1'b1);
      chk("lsu_rd", bus.rd, 5'd7);
      chk("lsu_wd", bus.wd, 32'h1234);
      chk("busy7_clr", bus.busy[7], 1'b0);
      chk("hz1_clr", bus.hz1, 1'b0);

      // Contention, backpressure and starvation guard
      drive(1, 10, 32'hA0, 1, 1, 32'h11, 0, 0, 0, 0);
      drive(1, 10, 32'hA1, 1, 2, 32'h22, 0, 0, 0, 0);
      chk("full_ready", bus.lsu_ready, 1'b0);
      drive(1, 10, 32'hA2, 1, 3, 32'h33, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 10, 32'hB0 + i, 0, 0, 0, 0, 0, 0, 0);
      chk("stall_on", bus.alu_stall, 1'b1);
      idle(0);
      chk("pop1_rd", bus.rd, 5'd1);
      chk("pop1_we", bus.we, 1'b1);
      chk("stall_off", bus.alu_stall, 1'b0);
      idle(0);
      chk("pop2_rd", bus.rd, 5'd2);
      chk("pop2_wd", bus.wd, 32'h22);
      idle(0);

      // x0 handling
      drive(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
      chk("x0_alu_we", bus.we, 1'b0);
      drive(0, 0, 0, 1, 0, 32'h66, 1, 0, 0, 0);
      idle(0);
      chk("x0_lsu_we", bus.we, 1'b0);
      chk("x0_ready", bus.lsu_ready, 1'b1);
      chk("x0_busy", bus.busy, 32'd0);

      // Same-cycle set and clear of one register
      drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
      drive(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      chk("sc_we", bus.we, 1'b1);
      chk("sc_rd", bus.rd, 5'd9);
      chk("sc_busy9", bus.busy[9], 1'b1);

      // Mid-operation reset
      drive(1, 12, 32'hC0, 1, 4, 32'h44, 1, 4, 0, 0);
      drive(1, 12, 32'hC1, 1, 5, 32'h45, 0, 0, 0, 0);
      pulse_reset();
      for (int i = 0; i < 3; i++) idle(4);
      chk("post_rst_we", bus.we, 1'b0);

      // Randomized traffic with phases of light and heavy ALU load
      for (int i = 0; i < 900; i++) begin
         mode = (i / 100) % 3;
         case (mode)
            0:       av = ($urandom_range(0, 99) < 20);
            1:       av = ($urandom_range(0, 99) < 85);
            default: av = ($urandom_range(0, 99) < 50);
         endcase
         if (m_stall && mode != 1) av = 1'b0;
         drive(av, 5'($urandom_range(0, 31)), $urandom,
               ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (i == 450) pulse_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
